// File: rtl/microprocessor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : microprocessor_pkg
// Description : Shared types and helpers for the microprocessor program
//               memory and its boot loader.
//               - loader_state_t : boot-loader FSM state encoding
//               - instr_width()  : instruction width from register-file bits
// Revision    : 1.0  initial release
// ============================================================================
package microprocessor_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    LO   = 3'd2,
    HI   = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } loader_state_t;

  // Opcode nibble plus two register-file operand fields.
  function automatic int instr_width(input int rf_address_bits);
    return 4 + 2 * rf_address_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rom_array.sv
`default_nettype none
// ============================================================================
// Module      : rom_array
// Description : Instruction storage with one write port and one registered,
//               enabled read port. No reset, so it maps onto block RAM.
// Ports       : clk      - clock, rising edge
//               wr_en    - write strobe
//               wr_addr  - write address
//               wr_data  - write word
//               rd_en    - read strobe; rd_data holds while low
//               rd_addr  - read address
//               rd_data  - registered read word (1-cycle latency)
// Revision    : 1.0  initial release
// ============================================================================
module rom_array
  import microprocessor_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 10,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= r_mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : rom_loader
// Description : Program memory feeding the processor instruction port. The
//               array is filled at boot from a byte-serial valid/ready stream
//               (count header, then LO/HI byte per instruction); the
//               processor is held in reset until a full program is resident.
// Ports       : clk, rst_n          - clock / async active-low reset
//               load_start         - pulse: start or restart a load
//               load_valid/data    - load byte stream
//               load_ready         - loader accepts a byte this cycle
//               load_done          - program resident, processor released
//               load_error         - bad header (sticky until load_start)
//               cpu_rst_n          - active-low processor reset
//               ROM_readEnable     - processor read request
//               ROM_address        - processor read address
//               ROM_data           - instruction word (1-cycle latency)
// Revision    : 1.0  initial release
// ============================================================================
module rom_loader
  import microprocessor_pkg::*;
#(
  parameter int ROM_addressBits = 6,
  parameter int RF_addressBits  = 3,
  localparam int IW             = instr_width(RF_addressBits)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_start,
  input  logic                       load_valid,
  input  logic [7:0]                 load_data,
  output logic                       load_ready,
  output logic                       load_done,
  output logic                       load_error,
  output logic                       cpu_rst_n,
  input  logic                       ROM_readEnable,
  input  logic [ROM_addressBits-1:0] ROM_address,
  output logic [IW-1:0]              ROM_data
);

  localparam int c_depth = 2 ** ROM_addressBits;

  loader_state_t              r_state;
  loader_state_t              w_next;
  logic [ROM_addressBits-1:0] r_addr;
  logic [ROM_addressBits:0]   r_count;
  logic [7:0]                 r_lo;
  logic                       r_rd_seen;

  logic                       w_accept;
  logic                       w_hdr_bad;
  logic                       w_last;
  logic                       w_wr_en;
  logic [IW-1:0]              w_wr_data;
  logic                       w_rd_en;
  logic [IW-1:0]              w_rd_data;

  // Status outputs are pure state decodes.
  assign load_ready = (r_state == HDR) || (r_state == LO) || (r_state == HI);
  assign load_done  = (r_state == DONE);
  assign cpu_rst_n  = (r_state == DONE);
  assign load_error = (r_state == ERR);

  // A restart pulse wins over a byte offered on the same edge.
  assign w_accept  = load_valid && load_ready && !load_start;

  // Header is checked at full 32-bit width so out-of-range bytes never alias
  // into the (ROM_addressBits+1)-bit count register.
  assign w_hdr_bad = (load_data == 8'd0) || (32'(load_data) > c_depth);
  assign w_last    = ({1'b0, r_addr} == (r_count - 1'b1));

  assign w_wr_en   = w_accept && (r_state == HI);
  assign w_wr_data = {load_data[IW-9:0], r_lo};
  assign w_rd_en   = (r_state == DONE) && ROM_readEnable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (load_start) begin
      w_next = HDR;
    end else begin
      unique case (r_state)
        IDLE: w_next = IDLE;
        HDR:  if (w_accept) w_next = w_hdr_bad ? ERR : LO;
        LO:   if (w_accept) w_next = HI;
        HI:   if (w_accept) w_next = w_last ? DONE : LO;
        DONE: w_next = DONE;
        ERR:  w_next = ERR;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_count   <= '0;
      r_lo      <= '0;
      r_rd_seen <= 1'b0;
    end else begin
      if (load_start) begin
        r_addr <= '0;
      end else if (w_accept) begin
        unique case (r_state)
          HDR: begin
            if (!w_hdr_bad) begin
              r_count <= (ROM_addressBits+1)'(load_data);
            end
            r_addr <= '0;
          end
          LO: r_lo <= load_data;
          HI: if (!w_last) r_addr <= r_addr + 1'b1;
          default: ;
        endcase
      end
      if (w_rd_en) begin
        r_rd_seen <= 1'b1;
      end
    end
  end

  // The array read register has no reset; ROM_data reads as zero until the
  // first read after reset has loaded that register.
  assign ROM_data = r_rd_seen ? w_rd_data : '0;

  rom_array #(
    .DEPTH (c_depth),
    .WIDTH (IW)
  ) u_rom_array (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .wr_addr (r_addr),
    .wr_data (w_wr_data),
    .rd_en   (w_rd_en),
    .rd_addr (ROM_address),
    .rd_data (w_rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_loader
// Description : Directed self-checking bench for rom_loader. A bench-side
//               array model records every word sent; reads push the modelled
//               word into a queue that is popped when ROM_data is sampled.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rom_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       load_done;
  logic       load_error;
  logic       cpu_rst_n;
  logic       ROM_readEnable;
  logic [5:0] ROM_address;
  logic [9:0] ROM_data;

  int         checks = 0;
  int         errors = 0;
  logic [9:0] model [64];
  logic [9:0] exp_q [$];

  rom_loader #(
    .ROM_addressBits (6),
    .RF_addressBits  (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_start     (load_start),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .load_ready     (load_ready),
    .load_done      (load_done),
    .load_error     (load_error),
    .cpu_rst_n      (cpu_rst_n),
    .ROM_readEnable (ROM_readEnable),
    .ROM_address    (ROM_address),
    .ROM_data       (ROM_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Offer one byte and hold it until it is taken; optional idle gap after.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int guard = 0;
    load_valid = 1'b1;
    load_data  = b;
    while (!load_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) check("ready_timeout", 32'(load_ready), 32'd1);
    tick();
    load_valid = 1'b0;
    if (gap) begin
      load_data = 8'hEE;
      tick();
    end
  endtask

  task automatic send_word(input int idx, input logic [7:0] lo, input logic [7:0] hi,
                           input bit gap);
    send_byte(lo, gap);
    if (gap) check("gap_hold_hi", 32'(load_ready), 32'd1);
    send_byte(hi, gap);
    model[idx] = {hi[1:0], lo};
  endtask

  task automatic read_check(input logic [5:0] a);
    ROM_readEnable = 1'b1;
    ROM_address    = a;
    exp_q.push_back(model[a]);
    tick();
    ROM_readEnable = 1'b0;
    check("rom_read", 32'(ROM_data), 32'(exp_q.pop_front()));
  endtask

  task automatic load_three(input bit gap);
    pulse_start();
    send_byte(8'h03, gap);
    send_word(0, 8'h34, 8'h02, gap);
    send_word(1, 8'h7F, 8'h03, gap);
    check("done_early", 32'(load_done), 32'd0);
    send_word(2, 8'h00, 8'h01, gap);
    check("done_after_last", 32'(load_done), 32'd1);
    check("cpu_rst_after_last", 32'(cpu_rst_n), 32'd1);
  endtask

  initial begin
    rst_n          = 1'b0;
    load_start     = 1'b0;
    load_valid     = 1'b0;
    load_data      = 8'h00;
    ROM_readEnable = 1'b0;
    ROM_address    = '0;

    // Reset then idle
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("idle_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      check("idle_ready", 32'(load_ready), 32'd0);
      check("idle_rom_data", 32'(ROM_data), 32'd0);
      check("idle_done", 32'(load_done), 32'd0);
      tick();
    end

    // Basic 3-instruction load
    load_three(1'b0);
    read_check(6'd1);
    ROM_address = 6'd0;
    tick();
    check("rom_hold_no_en", 32'(ROM_data), 32'h37F);
    read_check(6'd0);
    read_check(6'd2);

    // Same stream with idle gaps between bytes
    for (int i = 0; i < 3; i++) model[i] = 10'h000;
    load_three(1'b1);
    read_check(6'd0);
    read_check(6'd1);
    read_check(6'd2);

    // Bad headers
    pulse_start();
    send_byte(8'h00, 1'b0);
    check("hdr0_error", 32'(load_error), 32'd1);
    check("hdr0_ready", 32'(load_ready), 32'd0);
    check("hdr0_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    pulse_start();
    check("restart_clears_error", 32'(load_error), 32'd0);
    send_byte(8'h41, 1'b0);
    check("hdr65_error", 32'(load_error), 32'd1);
    pulse_start();
    send_byte(8'h40, 1'b0);
    check("hdr64_no_error", 32'(load_error), 32'd0);
    check("hdr64_ready", 32'(load_ready), 32'd1);

    // Restart mid-load
    pulse_start();
    send_byte(8'h04, 1'b0);
    send_word(0, 8'hAB, 8'h01, 1'b0);
    send_byte(8'hCD, 1'b0);
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_word(0, 8'hAA, 8'h03, 1'b0);
    check("restart_done", 32'(load_done), 32'd1);
    read_check(6'd0);

    // Reload from DONE drops the processor reset right away
    pulse_start();
    check("reload_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("reload_done", 32'(load_done), 32'd0);

    // Start coincident with a valid byte: byte must not be consumed
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'h02;
    tick();
    load_start = 1'b0;
    load_valid = 1'b0;
    send_byte(8'h01, 1'b0);
    send_word(0, 8'h55, 8'h02, 1'b0);
    check("start_priority_done", 32'(load_done), 32'd1);
    read_check(6'd0);

    // Async reset during HI
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("async_ready", 32'(load_ready), 32'd0);
    check("async_done", 32'(load_done), 32'd0);
    check("async_error", 32'(load_error), 32'd0);
    check("async_rom_data", 32'(ROM_data), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
